// File: rtl/rgb_breathe_pkg.sv
// Shared types and colour codes for the breathe PWM driver and the colour sequencer.
package rgb_breathe_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    DONE      = 3'd4
  } breathe_state_t;

  // bit0 = red, bit1 = green, bit2 = blue
  localparam logic [2:0] COLOR_OFF   = 3'b000;
  localparam logic [2:0] COLOR_RED   = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_BLUE  = 3'b100;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM counter with a period-boundary strobe and a clearable period counter.
module pwm_period_timer #(
  parameter int PWM_BITS = 8,
  parameter int PER_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                per_clr_i,
  output logic [PWM_BITS-1:0] pcnt_o,
  output logic                boundary_o,
  output logic [PER_W-1:0]    per_o
);

  logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
  logic [PER_W-1:0]    per_q, per_d;

  always_comb begin
    pcnt_d     = pcnt_q + PWM_BITS'(1);
    boundary_o = (pcnt_q == '1);
    per_d      = per_q;
    // A clear wins over a boundary on the same edge, so per restarts at 0.
    if (per_clr_i) begin
      per_d = '0;
    end else if (boundary_o) begin
      per_d = per_q + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      per_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
    end
  end

  assign pcnt_o = pcnt_q;
  assign per_o  = per_q;

endmodule

// File: rtl/rgb_breathe_pwm.sv
// Runs one shared breathe envelope (up, hold, down) per accepted colour and drives
// three PWM LED outputs; colour changes only take effect between envelopes.
module rgb_breathe_pwm
  import rgb_breathe_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] color_i,
  input  logic       color_valid_i,
  output logic       color_ready_o,
  output logic       red_led,
  output logic       green_led,
  output logic       blue_led,
  output logic       busy_o,
  output logic       cycle_done_o,
  output logic [2:0] dbg_state_o
);

  localparam int PER_MAX = (HOLD_PERIODS > STEP_PERIODS) ? HOLD_PERIODS : STEP_PERIODS;
  localparam int PER_W   = $clog2(PER_MAX) + 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [PER_W-1:0]    STEP_LAST = PER_W'(STEP_PERIODS - 1);
  localparam logic [PER_W-1:0]    HOLD_LAST = PER_W'(HOLD_PERIODS - 1);

  breathe_state_t      state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [2:0]          color_q, color_d;
  logic [2:0]          led_q, led_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [PWM_BITS-1:0] pcnt;
  logic [PER_W-1:0]    per;
  logic                boundary;
  logic                per_step;
  logic                per_clr;
  logic [PWM_BITS-1:0] lvl_inc, lvl_dec;

  pwm_period_timer #(
    .PWM_BITS (PWM_BITS),
    .PER_W    (PER_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .per_clr_i  (per_clr),
    .pcnt_o     (pcnt),
    .boundary_o (boundary),
    .per_o      (per)
  );

  // Handshake: a colour transfers on a rising edge where color_valid_i and
  // color_ready_o are both 1; ready is registered and high only in IDLE, so
  // valid outside IDLE is simply held by the sender until the envelope ends.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    color_d  = color_q;
    per_step = 1'b0;
    lvl_inc  = (level_q == LVL_MAX) ? LVL_MAX : level_q + PWM_BITS'(1);
    lvl_dec  = (level_q == '0) ? '0 : level_q - PWM_BITS'(1);

    case (state_q)
      IDLE: begin
        level_d = '0;
        if (color_valid_i && ready_q) begin
          color_d = color_i;
          state_d = (color_i == COLOR_OFF) ? DONE : RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (boundary && (per == STEP_LAST)) begin
          per_step = 1'b1;
          level_d  = lvl_inc;
          if (lvl_inc == LVL_MAX) state_d = HOLD;
        end
      end
      HOLD: begin
        if (boundary && (per == HOLD_LAST)) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (boundary && (per == STEP_LAST)) begin
          per_step = 1'b1;
          level_d  = lvl_dec;
          if (lvl_dec == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    per_clr = per_step || (state_d != state_q);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RAMP_UP) || (state_d == HOLD) || (state_d == RAMP_DOWN);
    done_d  = (state_d == DONE);

    for (int i = 0; i < 3; i++) begin
      led_d[i] = (pcnt < level_q) && color_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      level_q <= '0;
      color_q <= '0;
      led_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      color_q <= color_d;
      led_q   <= led_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign color_ready_o = ready_q;
  assign busy_o        = busy_q;
  assign cycle_done_o  = done_q;
  assign red_led       = led_q[0];
  assign green_led     = led_q[1];
  assign blue_led      = led_q[2];
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rgb_breathe_pwm.sv
// Bench for rgb_breathe_pwm at PWM_BITS=3, STEP_PERIODS=1, HOLD_PERIODS=2.
module tb_rgb_breathe_pwm;
  import rgb_breathe_pkg::*;

  localparam int TB_MAX  = 7;
  localparam int TB_STEP = 1;
  localparam int TB_HOLD = 2;
  localparam int ENV_B   = 2 * TB_MAX * TB_STEP + TB_HOLD;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] color_i = 3'b000;
  logic       color_valid_i = 1'b0;
  logic       color_ready_o, red_led, green_led, blue_led, busy_o, cycle_done_o;
  logic [2:0] dbg_state_o;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  rgb_breathe_pwm #(
    .PWM_BITS     (3),
    .STEP_PERIODS (TB_STEP),
    .HOLD_PERIODS (TB_HOLD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .color_i       (color_i),
    .color_valid_i (color_valid_i),
    .color_ready_o (color_ready_o),
    .red_led       (red_led),
    .green_led     (green_led),
    .blue_led      (blue_led),
    .busy_o        (busy_o),
    .cycle_done_o  (cycle_done_o),
    .dbg_state_o   (dbg_state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Brightness is a function of boundaries seen since acceptance.
  function automatic int lvl_of(input int b);
    if (b <= TB_MAX * TB_STEP) return b / TB_STEP;
    if (b < TB_MAX * TB_STEP + TB_HOLD) return TB_MAX;
    return TB_MAX - (b - TB_MAX * TB_STEP - TB_HOLD) / TB_STEP;
  endfunction

  int         m_pcnt = 0;
  int         m_phase = 0;  // 0 idle, 1 envelope running, 2 done cycle
  int         m_b = 0;
  int         m_lvl = 0;
  logic [2:0] m_col = 3'b000;
  logic [2:0] m_led = 3'b000;
  logic       m_rdy = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pcnt = 0; m_phase = 0; m_b = 0; m_lvl = 0; m_col = 3'b000; m_led = 3'b000;
      m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) m_led[ch] = (m_pcnt < m_lvl) && m_col[ch];
      case (m_phase)
        1: if (m_pcnt == TB_MAX) begin
             m_b++;
             if (m_b == ENV_B) m_phase = 2;
           end
        2: m_phase = 0;
        default: if (m_rdy && color_valid_i) begin
                   m_col   = color_i;
                   m_b     = 0;
                   m_phase = (color_i == 3'b000) ? 2 : 1;
                 end
      endcase
      m_lvl  = (m_phase == 1) ? lvl_of(m_b) : 0;
      m_rdy  = (m_phase == 0);
      m_busy = (m_phase == 1);
      m_done = (m_phase == 2);
      m_pcnt = (m_pcnt + 1) % (TB_MAX + 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", int'(color_ready_o), int'(m_rdy));
      check("busy",  int'(busy_o),        int'(m_busy));
      check("done",  int'(cycle_done_o),  int'(m_done));
      check("leds",  int'({blue_led, green_led, red_led}), int'(m_led));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [2:0] c, output bit saw_done, output int waited);
    bit acc;
    acc = 1'b0; saw_done = 1'b0; waited = 0;
    @(posedge clk); #1;
    color_i = c; color_valid_i = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (cycle_done_o) saw_done = 1'b1;
      if (color_ready_o) begin
        @(posedge clk); #1;
        color_valid_i = 1'b0;
        color_i = 3'($urandom_range(0, 7));
        acc = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!acc) begin
      check("accept_seen", int'(color_ready_o), 1);
      color_valid_i = 1'b0;
    end
  endtask

  int         env_b, env_r, env_g, env_bl, env_hold;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  // Observes one envelope from just after acceptance until the done pulse.
  task automatic run_envelope(input int ch, input logic [2:0] col);
    int   win;
    bit   first;
    logic [2:0] leds;
    env_b = 0; env_r = 0; env_g = 0; env_bl = 0; env_hold = 0;
    got_q.delete(); win = 0; first = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!first && m_pcnt == 0) env_b++;
      first = 1'b0;
      leds = {blue_led, green_led, red_led};
      env_r  += int'(red_led);
      env_g  += int'(green_led);
      env_bl += int'(blue_led);
      win    += int'(leds[ch]);
      if (m_pcnt == 0) begin
        if (win != 0) got_q.push_back(4'(win));
        win = 0;
      end
      if (dbg_state_o == 3'(HOLD)) begin
        env_hold++;
        check("hold_pwm", int'(leds), (m_pcnt != 0) ? int'(col) : 0);
      end
      if (cycle_done_o) return;
    end
    check("envelope_done_seen", int'(cycle_done_o), 1);
  endtask

  task automatic cmp_windows(input string tag);
    check({tag, "_win_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_win"}, int'(got_q[i]), int'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit sd;
    int wt, nb, ndone;
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7,
              4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    // Reset
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_leds", int'({blue_led, green_led, red_led}), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(cycle_done_o), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_ready_after_edge", int'(color_ready_o), 1);

    // Full red envelope
    offer(COLOR_RED, sd, wt);
    run_envelope(0, COLOR_RED);
    check("red_boundaries", env_b, 16);
    check("red_high_total", env_r, 63);
    check("red_green_total", env_g, 0);
    check("red_blue_total", env_bl, 0);
    check("red_hold_cycles", env_hold, 16);
    cmp_windows("red");
    @(negedge clk);
    check("red_done_one_cycle", int'(cycle_done_o), 0);
    check("red_ready_back", int'(color_ready_o), 1);

    // Zero colour
    offer(COLOR_OFF, sd, wt);
    @(negedge clk);
    check("zero_done_next", int'(cycle_done_o), 1);
    check("zero_busy", int'(busy_o), 0);
    check("zero_ready_low", int'(color_ready_o), 0);
    @(negedge clk);
    check("zero_ready_2cyc", int'(color_ready_o), 1);
    check("zero_done_drop", int'(cycle_done_o), 0);

    // Back-pressure: cyan offered during a yellow envelope
    offer(3'b011, sd, wt);
    offer(3'b110, sd, wt);
    check("bp_saw_done_first", int'(sd), 1);
    check("bp_waited_envelope", int'(wt >= 120), 1);
    run_envelope(1, 3'b110);
    check("cyan_red_total", env_r, 0);
    check("cyan_green_total", env_g, 63);
    check("cyan_blue_total", env_bl, 63);
    cmp_windows("cyan");

    // Mid-envelope reset during HOLD
    offer(COLOR_RED, sd, wt);
    nb = 0;
    for (int i = 0; i < 200 && nb < 8; i++) begin
      @(negedge clk);
      if (i > 0 && m_pcnt == 0) nb++;
    end
    check("mid_in_hold", int'(dbg_state_o), int'(HOLD));
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check("mid_async_leds", int'({blue_led, green_led, red_led}), 0);
    check("mid_async_busy", int'(busy_o), 0);
    check("mid_async_ready", int'(color_ready_o), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ndone += int'(cycle_done_o);
    end
    check("mid_no_done_pulse", ndone, 0);

    // White, starting again from level 0, with the peak observed
    offer(COLOR_WHITE, sd, wt);
    run_envelope(2, COLOR_WHITE);
    check("white_boundaries", env_b, 16);
    check("white_hold_cycles", env_hold, 16);
    check("white_red_total", env_r, 63);
    check("white_green_total", env_g, 63);
    check("white_blue_total", env_bl, 63);
    cmp_windows("white");

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
